// File: rtl/fft_band_scan_avalon_mm_pkg.sv
// fft_scan_pkg: shared constants for the FFT band scanner.
//   - Avalon register word addresses
//   - CTRL / STATUS bit positions
//   - scan FSM state encoding
// Ports: none (package).
package fft_scan_pkg;

  localparam logic [4:0] REG_CTRL      = 5'd0;
  localparam logic [4:0] REG_STATUS    = 5'd1;
  localparam logic [4:0] REG_THRESH    = 5'd2;
  localparam logic [4:0] REG_HITS      = 5'd3;
  localparam logic [4:0] REG_EXP       = 5'd4;
  localparam logic [4:0] REG_PEAK_BASE = 5'd8;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

endpackage

// File: rtl/fft_band_scan_avalon_mm_if.sv
// Avalon-MM bus bundle for the FFT band scanner register file.
//   address[4:0], writedata[31:0], byteenable[3:0], write, read, chipselect
//   readdata[31:0] (registered by the slave, read latency 1)
// Modports: master (bus driver / Nios side), slave (scanner side).
interface fft_band_scan_avalon_mm_if;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [31:0] readdata;

  modport master (
    output address, writedata, byteenable, write, read, chipselect,
    input  readdata
  );

  modport slave (
    input  address, writedata, byteenable, write, read, chipselect,
    output readdata
  );
endinterface

// File: rtl/fft_band_scan_avalon_mm_peak_tracker.sv
// fft_peak_tracker: scratch max/argmax for one band.
//   clk      in  clock
//   clr      in  clear peak to 0 / bin 0 (start of a run)
//   en       in  candidate bin belongs to this band and is valid
//   power    in  candidate power
//   bin      in  candidate bin index
//   peak_pwr out running maximum power
//   peak_bin out bin of the running maximum (first bin wins on ties)
module fft_peak_tracker
  import fft_scan_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int POWER_W = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [POWER_W-1:0] power,
  input  logic [ADDR_W-1:0]  bin,
  output logic [POWER_W-1:0] peak_pwr,
  output logic [ADDR_W-1:0]  peak_bin
);

  // Strict compare: bins arrive in ascending order, so the lowest bin keeps a tie.
  always_ff @(posedge clk) begin
    if (clr) begin
      peak_pwr <= '0;
      peak_bin <= '0;
    end else if (en && (power > peak_pwr)) begin
      peak_pwr <= power;
      peak_bin <= bin;
    end
  end

endmodule

// File: rtl/fft_band_scan_avalon_mm.sv
// fft_band_scan_avalon_mm: Avalon-MM slave that runs the audio FFT core, sweeps the
// half spectrum and keeps the peak power / peak bin of each of NUM_BANDS bands.
// Results are double-buffered: visible registers only change at the end of a run.
//   clk, reset       clock, synchronous active-high reset
//   avs              Avalon-MM slave bundle (fft_band_scan_avalon_mm_if.slave)
//   fft_addr/start   bin address and run request to the FFT core
//   fft_done/power/exp  result-ready level, bin power (RD_LAT late), block exponent
//   irq              level interrupt, only when FFT_SCAN_IRQ_EN is defined (else 0)
module fft_band_scan_avalon_mm
  import fft_scan_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int POWER_W   = 16,
  parameter int EXP_W     = 6,
  parameter int NUM_BANDS = 4,
  parameter int RD_LAT    = 2,
  parameter int BIN_SKIP  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_band_scan_avalon_mm_if.slave avs,
  output logic [ADDR_W-1:0]     fft_addr,
  output logic                  fft_start,
  input  logic                  fft_done,
  input  logic [POWER_W-1:0]    fft_power,
  input  logic [EXP_W-1:0]      fft_exp,
  output logic                  irq
);

  localparam int NBINS      = 2**(ADDR_W-1);
  localparam int BAND_SHIFT = ADDR_W - 1 - $clog2(NUM_BANDS);
  localparam int DCNT_W     = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NBINS - 1);

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction

  logic [2:0]           state;
  logic [DCNT_W-1:0]    drain_cnt;
  logic                 continuous, irq_en, done, overrun;
  logic [POWER_W-1:0]   thresh;
  logic [EXP_W-1:0]     exp_scan, exp_vis;
  logic [NUM_BANDS-1:0] hits, band_en;
  logic [POWER_W-1:0]   scr_pwr [NUM_BANDS];
  logic [POWER_W-1:0]   vis_pwr [NUM_BANDS];
  logic [ADDR_W-1:0]    scr_bin [NUM_BANDS];
  logic [ADDR_W-1:0]    vis_bin [NUM_BANDS];
  logic [ADDR_W-1:0]    bin_p [RD_LAT];
  logic [RD_LAT-1:0]    vld_p;
  logic [31:0]          rd_mux, readdata_q;

  logic wr, rd, wr_ctrl, start_wr, w1c_done, w1c_ovr, commit, clr_scratch, busy;

  assign wr        = avs.chipselect & avs.write;
  assign rd        = avs.chipselect & avs.read;
  assign wr_ctrl   = wr && (avs.address == REG_CTRL) && avs.byteenable[0];
  assign start_wr  = wr_ctrl && avs.writedata[CTRL_START];
  assign w1c_done  = wr && (avs.address == REG_STATUS) && avs.byteenable[0] &&
                     avs.writedata[STAT_DONE];
  assign w1c_ovr   = wr && (avs.address == REG_STATUS) && avs.byteenable[0] &&
                     avs.writedata[STAT_OVR];
  assign busy      = (state != S_IDLE);
  assign commit    = (state == S_COMMIT);
  // Scratch peaks are wiped on every entry into REQ.
  assign clr_scratch = ((state == S_IDLE) && start_wr) || (commit && continuous);

  // Scan FSM: REQ holds fft_start until the core reports done, SCAN walks the
  // half spectrum, DRAIN lets the last RD_LAT bins leave the read pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      fft_start <= 1'b0;
      fft_addr  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_wr) begin
          state     <= S_REQ;
          fft_start <= 1'b1;
        end
        S_REQ: if (fft_done) begin
          state     <= S_SCAN;
          fft_start <= 1'b0;
          fft_addr  <= '0;
        end
        S_SCAN: if (fft_addr == LAST_BIN) begin
          state     <= S_DRAIN;
          drain_cnt <= '0;
        end else begin
          fft_addr  <= fft_addr + 1'b1;
        end
        S_DRAIN: if (drain_cnt == DCNT_W'(RD_LAT - 1)) state <= S_COMMIT;
                 else drain_cnt <= drain_cnt + 1'b1;
        S_COMMIT: if (continuous) begin
          state     <= S_REQ;
          fft_start <= 1'b1;
        end else begin
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_REQ) && fft_done) exp_scan <= fft_exp;
  end

  // Read-latency pipe stage: bin index travels with its valid flag
  always_ff @(posedge clk) begin
    bin_p[0] <= fft_addr;
    for (int i = 1; i < RD_LAT; i++) bin_p[i] <= bin_p[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p <= '0;
    else begin
      vld_p[0] <= (state == S_SCAN);
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_comb begin
    band_en = '0;
    for (int b = 0; b < NUM_BANDS; b++)
      band_en[b] = vld_p[RD_LAT-1] && (int'(bin_p[RD_LAT-1]) >= BIN_SKIP) &&
                   ((int'(bin_p[RD_LAT-1]) >> BAND_SHIFT) == b);
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
    fft_peak_tracker #(.ADDR_W(ADDR_W), .POWER_W(POWER_W)) u_trk (
      .clk      (clk),
      .clr      (clr_scratch),
      .en       (band_en[g]),
      .power    (fft_power),
      .bin      (bin_p[RD_LAT-1]),
      .peak_pwr (scr_pwr[g]),
      .peak_bin (scr_bin[g])
    );
  end

  // Register file and commit stage; COMMIT beats a same-cycle W1C of done.
  always_ff @(posedge clk) begin
    if (reset) begin
      continuous <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      thresh     <= '0;
      hits       <= '0;
      exp_vis    <= '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        vis_pwr[b] <= '0;
        vis_bin[b] <= '0;
      end
    end else begin
      if (wr_ctrl) continuous <= avs.writedata[CTRL_CONT];
      if (wr && (avs.address == REG_THRESH))
        thresh <= POWER_W'(be_merge(32'(thresh), avs.writedata, avs.byteenable));
      done    <= commit | (done & ~w1c_done);
      overrun <= (overrun & ~w1c_ovr) | (commit & done & ~w1c_done);
      if (commit) begin
        exp_vis <= exp_scan;
        for (int b = 0; b < NUM_BANDS; b++) begin
          vis_pwr[b] <= scr_pwr[b];
          vis_bin[b] <= scr_bin[b];
          hits[b]    <= (scr_pwr[b] >= thresh);
        end
      end
    end
  end

`ifdef FFT_SCAN_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= avs.writedata[CTRL_IRQ_EN];
      irq <= done & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs.address)
      REG_CTRL:   begin
        rd_mux[CTRL_CONT]   = continuous;
        rd_mux[CTRL_IRQ_EN] = irq_en;
      end
      REG_STATUS: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done;
        rd_mux[STAT_OVR]  = overrun;
      end
      REG_THRESH: rd_mux = 32'(thresh);
      REG_HITS:   rd_mux = 32'(hits);
      REG_EXP:    rd_mux = 32'(exp_vis);
      default: begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          if (avs.address == 5'(int'(REG_PEAK_BASE) + 2*b))     rd_mux = 32'(vis_pwr[b]);
          if (avs.address == 5'(int'(REG_PEAK_BASE) + 2*b + 1)) rd_mux = 32'(vis_bin[b]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)   readdata_q <= '0;
    else if (rd) readdata_q <= rd_mux;
  end

  assign avs.readdata = readdata_q;

endmodule

// File: tb/tb_fft_band_scan_avalon_mm.sv
// Self-checking bench for fft_band_scan_avalon_mm: FFT core model with injectable
// spikes, randomized spectra and thresholds, reference peaks computed per band.
module tb_fft_band_scan_avalon_mm;
  localparam int ADDR_W = 10, POWER_W = 16, EXP_W = 6, NUM_BANDS = 4, RD_LAT = 2, BIN_SKIP = 1;
  localparam int NBINS = 2**(ADDR_W-1);
  localparam int BW    = NBINS / NUM_BANDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [ADDR_W-1:0]  fft_addr;
  logic               fft_start;
  logic               fft_done = 1'b0;
  logic [POWER_W-1:0] fft_power;
  logic [EXP_W-1:0]   fft_exp;
  logic               irq;

  fft_band_scan_avalon_mm_if bus ();

  fft_band_scan_avalon_mm #(
    .ADDR_W(ADDR_W), .POWER_W(POWER_W), .EXP_W(EXP_W),
    .NUM_BANDS(NUM_BANDS), .RD_LAT(RD_LAT), .BIN_SKIP(BIN_SKIP)
  ) dut (
    .clk(clk), .reset(reset), .avs(bus),
    .fft_addr(fft_addr), .fft_start(fft_start), .fft_done(fft_done),
    .fft_power(fft_power), .fft_exp(fft_exp), .irq(irq)
  );

  // FFT core model
  int spike [NBINS];
  int done_cnt = 0;
  logic [POWER_W-1:0] pw_q [RD_LAT];

  function automatic int pow_of(int bin);
    return (spike[bin] >= 0) ? spike[bin] : bin * 3;
  endfunction

  always @(posedge clk) begin
    pw_q[0] <= POWER_W'(pow_of(int'(fft_addr)));
    for (int k = 1; k < RD_LAT; k++) pw_q[k] <= pw_q[k-1];
  end
  assign fft_power = pw_q[RD_LAT-1];

  always @(posedge clk) begin
    if (fft_start !== 1'b1) begin
      fft_done <= 1'b0;
      done_cnt <= 0;
    end else if (!fft_done) begin
      if (done_cnt == 4) fft_done <= 1'b1;
      done_cnt <= done_cnt + 1;
    end
  end

  // Reference model
  int exp_pwr [NUM_BANDS], exp_bin [NUM_BANDS], prev_pwr [NUM_BANDS];
  int thresh_m = 0;
  int exp_m = 0;

  function automatic void clear_spikes();
    for (int i = 0; i < NBINS; i++) spike[i] = -1;
  endfunction

  function automatic void model_peaks();
    for (int b = 0; b < NUM_BANDS; b++) begin
      prev_pwr[b] = exp_pwr[b];
      exp_pwr[b] = 0;
      exp_bin[b] = 0;
      for (int bin = b * BW; bin < (b + 1) * BW; bin++)
        if (bin >= BIN_SKIP && pow_of(bin) > exp_pwr[b]) begin
          exp_pwr[b] = pow_of(bin);
          exp_bin[b] = bin;
        end
    end
  endfunction

  function automatic logic [31:0] model_hits();
    logic [31:0] h = '0;
    for (int b = 0; b < NUM_BANDS; b++) h[b] = (exp_pwr[b] >= thresh_m);
    return h;
  endfunction

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic av_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.byteenable = be;
    bus.write = 1'b1; bus.chipselect = 1'b1;
    @(negedge clk);
    bus.write = 1'b0; bus.chipselect = 1'b0;
  endtask

  task automatic av_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1; bus.chipselect = 1'b1;
    @(negedge clk);
    bus.read = 1'b0; bus.chipselect = 1'b0;
    d = bus.readdata;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    av_read(a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic wait_idle();
    logic [31:0] st = 32'h1;
    for (int i = 0; i < 3000 && st[0]; i++) av_read(5'd1, st);
    check_eq("idle_reached", 32'(st[0]), 32'h0);
  endtask

  task automatic wait_scan();
    for (int i = 0; i < 50 && fft_start; i++) @(negedge clk);
    check_eq("scan_entered", 32'(fft_start), 32'h0);
  endtask

  task automatic check_results(input string pfx, input logic [31:0] status);
    rd_check({pfx, "_status"}, 5'd1, status);
    rd_check({pfx, "_hits"}, 5'd3, model_hits());
    rd_check({pfx, "_exp"}, 5'd4, 32'(exp_m));
    for (int b = 0; b < NUM_BANDS; b++) begin
      rd_check($sformatf("%s_pwr%0d", pfx, b), 5'(8 + 2*b), 32'(exp_pwr[b]));
      rd_check($sformatf("%s_bin%0d", pfx, b), 5'(9 + 2*b), 32'(exp_bin[b]));
    end
  endtask

  task automatic start_run(input logic [31:0] ctrl);
    exp_m = int'($urandom_range(0, 63));
    fft_exp = EXP_W'(exp_m);
    model_peaks();
    av_write(5'd0, ctrl | 32'h1, 4'hF);
  endtask

  logic [31:0] d;

  initial begin
    bus.address = '0; bus.writedata = '0; bus.byteenable = '0;
    bus.write = 1'b0; bus.read = 1'b0; bus.chipselect = 1'b0;
    fft_exp = '0;
    clear_spikes();
    for (int b = 0; b < NUM_BANDS; b++) begin exp_pwr[b] = 0; exp_bin[b] = 0; end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst_fft_addr", 32'(fft_addr), 0);
    check_eq("rst_fft_start", 32'(fft_start), 0);
    check_eq("rst_irq", 32'(irq), 0);
    for (int a = 0; a < 16; a++) rd_check($sformatf("rst_reg%0d", a), 5'(a), 0);

    // Spikes in bands 0 and 2, other bands peak at their top bin
    spike[40] = 900; spike[300] = 1200;
    start_run(32'h0);
    wait_idle();
    check_results("s1", 32'h2);
    check_eq("s1_irq_off", 32'(irq), 0);

    // Threshold with partial byte enables
    av_write(5'd2, 32'h0000_03E8, 4'b0011);
    av_write(5'd2, 32'hFFFF_FFFF, 4'b0000);
    av_write(5'd2, 32'hABCD_0000, 4'b1100);
    rd_check("thresh_rb", 5'd2, 32'h3E8);
    thresh_m = 1000;
    av_write(5'd1, 32'h2, 4'h1);
    rd_check("w1c_done", 5'd1, 32'h0);
    start_run(32'h0);
    wait_idle();
    check_results("s2", 32'h2);

    // Ties and excluded DC bin
    clear_spikes();
    spike[70] = 500; spike[90] = 500; spike[0] = 9999;
    av_write(5'd1, 32'h6, 4'h1);
    start_run(32'h0);
    wait_idle();
    check_results("s3", 32'h2);

    // Randomized spectra; reads mid-scan see the previous run, start while busy ignored
    for (int it = 0; it < 4; it++) begin
      clear_spikes();
      for (int s = 0; s < int'($urandom_range(1, 6)); s++)
        spike[$urandom_range(0, NBINS - 1)] = int'($urandom_range(0, 3000));
      thresh_m = int'($urandom_range(0, 2000));
      av_write(5'd2, 32'(thresh_m), 4'b0011);
      av_write(5'd1, 32'h6, 4'h1);
      start_run(32'h0);
      wait_scan();
      repeat (60) @(negedge clk);
      begin
        int b = int'($urandom_range(0, NUM_BANDS - 1));
        rd_check($sformatf("r%0d_midscan_pwr%0d", it, b), 5'(8 + 2*b), 32'(prev_pwr[b]));
      end
      av_write(5'd0, 32'h1, 4'h1);
      check_eq($sformatf("r%0d_no_restart", it), 32'(fft_start), 0);
      wait_idle();
      check_results($sformatf("r%0d", it), 32'h2);
    end

    // Continuous mode: two unacknowledged runs raise overrun
    av_write(5'd1, 32'h6, 4'h1);
    start_run(32'h2);
    d = '0;
    for (int i = 0; i < 3000 && !d[2]; i++) av_read(5'd1, d);
    check_eq("cont_status", d, 32'h7);
    av_write(5'd1, 32'h6, 4'h1);
    rd_check("cont_w1c", 5'd1, 32'h1);
    av_write(5'd0, 32'h0, 4'h1);
    rd_check("cont_ctrl_clr", 5'd0, 32'h0);
    wait_idle();
    check_results("cont", 32'h2);

    // Interrupt
    av_write(5'd1, 32'h6, 4'h1);
    av_write(5'd0, 32'h4, 4'h1);
`ifdef FFT_SCAN_IRQ_EN
    rd_check("irq_en_rb", 5'd0, 32'h4);
    start_run(32'h4);
    wait_scan();
    check_eq("irq_low_busy", 32'(irq), 0);
    wait_idle();
    check_eq("irq_high", 32'(irq), 1);
    av_write(5'd1, 32'h2, 4'h1);
    check_eq("irq_hold", 32'(irq), 1);
    @(negedge clk);
    check_eq("irq_fall", 32'(irq), 0);
`else
    rd_check("irq_en_rb", 5'd0, 32'h0);
    start_run(32'h4);
    wait_idle();
    check_eq("irq_tied", 32'(irq), 0);
    av_write(5'd1, 32'h2, 4'h1);
`endif
    av_write(5'd0, 32'h0, 4'h1);

    // Reset in the middle of a scan
    start_run(32'h0);
    wait_scan();
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_fft_addr", 32'(fft_addr), 0);
    check_eq("mid_rst_fft_start", 32'(fft_start), 0);
    check_eq("mid_rst_irq", 32'(irq), 0);
    check_eq("mid_rst_readdata", bus.readdata, 0);
    for (int a = 0; a < 16; a++) rd_check($sformatf("mid_rst_reg%0d", a), 5'(a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
